gray_counter_ctrl: RTL and testbench
====================================

// Module: gray_counter_ctrl
// PURPOSE
//   Parametrised N-bit Gray-code counter with an internal prescaler, up/down
//   count, run/hold/idle control, parallel Gray load and optional saturation.
//   It is the next-generation core of the Gray counter system: it drives
//   board LEDs directly and exposes the binary count and tick/wrap strobes.
// PARAMETERS
//   N        4          counter width in bits (>=2)
//   DIV      100000000  prescaler period in clk cycles per count step (>=1)
//   SATURATE 0          0 = wrap at the ends; 1 = hold at all-ones/zero
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous reset, ACTIVE-LOW
//   clk_en     in   1  global enable; 0 freezes the prescaler and counter
//   start      in   1  level, sampled each clk: IDLE/HOLD -> RUN
//   stop       in   1  level, sampled each clk: RUN -> HOLD, HOLD -> IDLE
//   dir        in   1  1 = count up, 0 = count down
//   load       in   1  load load_gray into the counter on the next edge
//   load_gray  in   N  Gray-coded load value
//   leds       out  N  registered Gray count
//   bin        out  N  registered binary count, always consistent with leds
//   tick       out  1  one-cycle pulse on each count step
//   wrap       out  1  one-cycle pulse when the count wraps (15->0 or 0->15)
//   running    out  1  1 while the FSM is in RUN
// BEHAVIOUR
//   - Reset (rst=0, async): FSM=IDLE, prescaler=0, bin=0, leds=0, tick=0,
//     wrap=0, running=0. All outputs are registered.
//   - FSM: IDLE --start--> RUN; RUN --stop--> HOLD; HOLD --start--> RUN;
//     HOLD --stop--> IDLE. On entering IDLE, bin/leds clear to 0.
//     When start and stop are both 1, stop wins.
//   - Prescaler pc counts 0..DIV-1 only when running && clk_en. A step is
//     due when pc==DIV-1 and the prescaler advances; pc then returns to 0.
//     HOLD keeps pc unchanged. Entering RUN from IDLE clears pc.
//   - Step: bin <= bin+1 (dir=1) or bin-1 (dir=0), modulo 2^N.
//     leds <= next_bin ^ (next_bin>>1), updated on the same edge as bin.
//     tick=1 in the cycle after the step edge, i.e. coincident with the new
//     leds value.
//   - wrap=1 with tick when up 2^N-1 -> 0 or down 0 -> 2^N-1.
//     If SATURATE=1, a step past an end leaves bin unchanged; tick still
//     pulses and wrap stays 0.
//   - load (any state, independent of clk_en): bin <= gray2bin(load_gray) and
//     leds <= load_gray on the next edge; pc clears to 0. The FSM state is
//     unchanged. load has priority over a step due in the same cycle; that
//     step is discarded, so tick=0 and wrap=0.
//   - A dir change takes effect on the next step. There is no glitch on leds:
//     exactly one bit changes per step, except on load and clear.
//   - A reset asserted mid-run returns to the reset state immediately. The
//     first step after release and start happens DIV cycles later.
// TESTING  (N=4, DIV=4 unless noted)
//   1 Assert rst=0 mid-RUN at bin=5 -> all outputs 0 asynchronously;
//     running=0 after release.
//   2 start=1, dir=1 from 0 -> tick every 4 cycles. leds 0000,0001,0011,
//     0010,0110,...,1000. Step 16 -> leds 0000 with wrap=1 for 1 cycle.
//   3 dir=0 from bin=0 -> next step leds=1000, bin=1111, wrap=1.
//   4 load=1, load_gray=1100 in RUN, in the cycle a step is due -> leds=1100,
//     bin=1000, tick=0. The next tick comes 4 cycles later.
//   5 stop -> HOLD: leds frozen, running=0. start resumes the prescaler
//     phase. stop, stop -> IDLE with leds=0000. start and stop together in
//     HOLD -> IDLE.
//   6 SATURATE=1, up at bin=1111 -> leds stay 1000, tick=1, wrap=0.
//     clk_en=0 for 10 cycles -> no tick, pc frozen.

Source files
------------

// File: rtl/gray_counter_ctrl.sv
// N-bit Gray-code counter with a prescaler, up/down stepping, run/hold/idle
// control, parallel Gray load and optional end-stop saturation.
module gray_counter_ctrl #(
  parameter int N        = 4,
  parameter int DIV      = 100000000,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         start,
  input  logic         stop,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_gray,
  output logic [N-1:0] leds,
  output logic [N-1:0] bin,
  output logic         tick,
  output logic         wrap,
  output logic         running
);

  localparam int              PC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [N-1:0]    r_bin;
  logic [N-1:0]    r_leds;
  logic [N-1:0]    w_bin_nxt;
  logic            r_tick;
  logic            r_wrap;
  logic            r_running;
  logic            w_tick_nxt;
  logic            w_wrap_nxt;
  logic            w_advance;
  logic            w_step;
  logic            w_at_end;
  logic            w_enter_run;
  logic            w_enter_idle;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start && !stop) w_state_nxt = S_RUN;
      S_RUN:   if (stop) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (stop)       w_state_nxt = S_IDLE;
        else if (start) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_advance    = (r_state == S_RUN) && clk_en;
  assign w_step       = w_advance && (r_pc == PC_LAST);
  assign w_at_end     = dir ? (r_bin == '1) : (r_bin == '0);
  assign w_enter_run  = (r_state == S_IDLE) && (w_state_nxt == S_RUN);
  assign w_enter_idle = (r_state == S_HOLD) && (w_state_nxt == S_IDLE);

  // HOLD leaves the prescaler phase untouched so a resume continues mid-period.
  always_comb begin
    w_pc_nxt = r_pc;
    if (load || w_enter_run) begin
      w_pc_nxt = '0;
    end else if (w_advance) begin
      w_pc_nxt = w_step ? '0 : r_pc + PC_W'(1);
    end
  end

  // Load beats both the idle clear and a due step; a discarded step gives no tick.
  always_comb begin
    w_bin_nxt  = r_bin;
    w_tick_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_bin_nxt = gray2bin(load_gray);
    end else if (w_enter_idle) begin
      w_bin_nxt = '0;
    end else if (w_step) begin
      w_tick_nxt = 1'b1;
      if (!(w_at_end && SATURATE)) begin
        w_bin_nxt  = dir ? r_bin + N'(1) : r_bin - N'(1);
        w_wrap_nxt = w_at_end;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_bin     <= '0;
      r_leds    <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_bin     <= w_bin_nxt;
      r_leds    <= w_bin_nxt ^ (w_bin_nxt >> 1);
      r_tick    <= w_tick_nxt;
      r_wrap    <= w_wrap_nxt;
      r_running <= (w_state_nxt == S_RUN);
    end
  end

  assign leds    = r_leds;
  assign bin     = r_bin;
  assign tick    = r_tick;
  assign wrap    = r_wrap;
  assign running = r_running;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Self-checking bench for gray_counter_ctrl: vector table, directed corner
// sequences and a randomized run against a behavioural model (N=4, DIV=4).
module tb_gray_counter_ctrl;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int MOD = 1 << N;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clk_en, start, stop, dir, load;
  logic [N-1:0] load_gray;
  logic [N-1:0] leds, bin, s_leds, s_bin;
  logic         tick, wrap, running, s_tick, s_wrap, s_running;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int mode;
    int pc;
    int bin;
    bit tick;
    bit wrap;
  } model_t;

  typedef struct {
    bit       st, sp, d, ld;
    bit [3:0] lg;
    bit       en;
    bit [3:0] leds, bin;
    bit       tick, wrap, run;
  } vec_t;

  vec_t   vecs[$];
  model_t m_wrap, m_sat;

  always #5 clk = ~clk;

  gray_counter_ctrl #(.N(N), .DIV(DIV), .SATURATE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .stop(stop),
    .dir(dir), .load(load), .load_gray(load_gray),
    .leds(leds), .bin(bin), .tick(tick), .wrap(wrap), .running(running)
  );

  gray_counter_ctrl #(.N(N), .DIV(DIV), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .stop(stop),
    .dir(dir), .load(load), .load_gray(load_gray),
    .leds(s_leds), .bin(s_bin), .tick(s_tick), .wrap(s_wrap), .running(s_running)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Gray decode by search: the value whose Gray image matches.
  function automatic int g2b(input int g);
    for (int b = 0; b < MOD; b++) if ((b ^ (b >> 1)) == g) return b;
    return 0;
  endfunction

  function automatic model_t model_next(input model_t cur, input bit sat,
                                        input bit st, input bit sp, input bit d,
                                        input bit ld, input int lg, input bit en);
    model_t nx = cur;
    bit     due = (cur.mode == M_RUN) && en && (cur.pc == DIV - 1);
    int     target;
    nx.tick = 1'b0;
    nx.wrap = 1'b0;
    if (cur.mode == M_RUN && en) nx.pc = (cur.pc + 1) % DIV;
    case (cur.mode)
      M_IDLE: if (st && !sp) begin nx.mode = M_RUN; nx.pc = 0; end
      M_RUN:  if (sp) nx.mode = M_HOLD;
      default: begin
        if (sp)      nx.mode = M_IDLE;
        else if (st) nx.mode = M_RUN;
      end
    endcase
    if (ld) begin
      nx.bin = g2b(lg);
      nx.pc  = 0;
    end else if (cur.mode == M_HOLD && nx.mode == M_IDLE) begin
      nx.bin = 0;
    end else if (due) begin
      nx.tick = 1'b1;
      target  = d ? cur.bin + 1 : cur.bin - 1;
      if (target < 0 || target >= MOD) begin
        if (!sat) begin
          nx.bin  = (target + MOD) % MOD;
          nx.wrap = 1'b1;
        end
      end else begin
        nx.bin = target;
      end
    end
    return nx;
  endfunction

  function automatic logic [10:0] model_pack(input model_t mm);
    return {4'(mm.bin ^ (mm.bin >> 1)), 4'(mm.bin), mm.tick, mm.wrap, mm.mode == M_RUN};
  endfunction

  task automatic add(input bit st, input bit sp, input bit d, input bit ld,
                     input bit [3:0] lg, input bit en, input bit [3:0] e_leds,
                     input bit [3:0] e_bin, input bit e_tick, input bit e_wrap,
                     input bit e_run);
    vec_t v;
    v.st = st; v.sp = sp; v.d = d; v.ld = ld; v.lg = lg; v.en = en;
    v.leds = e_leds; v.bin = e_bin; v.tick = e_tick; v.wrap = e_wrap; v.run = e_run;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; load = 1'b0; load_gray = '0; clk_en = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    dir = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    m_wrap = '{default: 0};
    m_sat  = '{default: 0};
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_tick(input string name, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!tick && cycles < 64);
    if (!tick) check({name, " tick timeout"}, 32'(tick), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ticks;

    idle_inputs();
    dir = 1'b1;
    do_reset();
    check("reset leds", 32'(leds), 32'd0);
    check("reset bin", 32'(bin), 32'd0);
    check("reset tick/wrap/run", 32'({tick, wrap, running}), 32'd0);

    // Table: count, hold/resume, dir change, load, clk_en, stop to idle.
    add(1,0,1,0, 0,1,  0,0,0,0,1);
    repeat (3) add(0,0,1,0, 0,1,  0,0,0,0,1);
    add(0,0,1,0, 0,1,  1,1,1,0,1);
    repeat (3) add(0,0,1,0, 0,1,  1,1,0,0,1);
    add(0,0,1,0, 0,1,  3,2,1,0,1);
    add(0,1,1,0, 0,1,  3,2,0,0,0);
    add(0,0,1,0, 0,1,  3,2,0,0,0);
    add(1,0,1,0, 0,1,  3,2,0,0,1);
    repeat (2) add(0,0,1,0, 0,1,  3,2,0,0,1);
    add(0,0,1,0, 0,1,  2,3,1,0,1);
    repeat (3) add(0,0,0,0, 0,1,  2,3,0,0,1);
    add(0,0,0,0, 0,1,  3,2,1,0,1);
    add(0,0,0,1,12,1, 12,8,0,0,1);
    repeat (3) add(0,0,0,0, 0,1, 12,8,0,0,1);
    add(0,0,0,0, 0,1,  4,7,1,0,1);
    repeat (2) add(0,0,0,0, 0,0,  4,7,0,0,1);
    repeat (3) add(0,0,0,0, 0,1,  4,7,0,0,1);
    add(0,0,0,0, 0,1,  5,6,1,0,1);
    add(0,1,0,0, 0,1,  5,6,0,0,0);
    add(0,1,0,0, 0,1,  0,0,0,0,0);
    add(1,1,0,0, 0,1,  0,0,0,0,0);
    foreach (vecs[i]) begin
      start = vecs[i].st; stop = vecs[i].sp; dir = vecs[i].d; load = vecs[i].ld;
      load_gray = vecs[i].lg; clk_en = vecs[i].en;
      step();
      check($sformatf("vec[%0d] {leds,bin,tick,wrap,run}", i),
            32'({leds, bin, tick, wrap, running}),
            32'({vecs[i].leds, vecs[i].bin, vecs[i].tick, vecs[i].wrap, vecs[i].run}));
    end
    idle_inputs();

    // Full up cycle: Gray sequence, tick period and wrap on step 16.
    do_reset();
    start_run();
    check("run after start", 32'(running), 32'd1);
    for (int k = 1; k <= MOD; k++) begin
      wait_tick($sformatf("up step %0d", k), cyc);
      check($sformatf("up step %0d period", k), 32'(cyc), 32'(DIV));
      check($sformatf("up step %0d leds", k), 32'(leds), 32'((k % MOD) ^ ((k % MOD) >> 1)));
      check($sformatf("up step %0d wrap", k), 32'(wrap), 32'(k == MOD));
    end
    step();
    check("wrap one cycle", 32'({tick, wrap}), 32'd0);

    // Down from 0, plus saturating instance holding at zero.
    do_reset();
    dir = 1'b0;
    start_run();
    wait_tick("down from 0", cyc);
    check("down wrap leds", 32'(leds), 32'b1000);
    check("down wrap bin", 32'(bin), 32'hF);
    check("down wrap flag", 32'(wrap), 32'd1);
    check("sat down {leds,bin,tick,wrap}", 32'({s_leds, s_bin, s_tick, s_wrap}), 32'h0_0_2);

    // Load in the cycle a step is due.
    dir = 1'b1;
    repeat (DIV - 1) step();
    load = 1'b1; load_gray = 4'b1100;
    step();
    load = 1'b0;
    check("load leds", 32'(leds), 32'b1100);
    check("load bin", 32'(bin), 32'b1000);
    check("load drops step", 32'({tick, wrap, running}), 32'b001);
    wait_tick("after load", cyc);
    check("after load period", 32'(cyc), 32'(DIV));
    check("after load leds", 32'(leds), 32'b1101);

    // HOLD freezes and resumes the prescaler phase.
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("hold running", 32'(running), 32'd0);
    ticks = 0;
    repeat (6) begin step(); ticks += int'(tick); end
    check("hold no tick", 32'(ticks), 32'd0);
    check("hold leds frozen", 32'(leds), 32'b1101);
    start_run();
    wait_tick("resume", cyc);
    check("resume phase", 32'(cyc), 32'd2);
    stop = 1'b1;
    step();
    step();
    stop = 1'b0;
    check("stop stop idle {leds,bin,run}", 32'({leds, bin, running}), 32'd0);
    start_run();
    wait_tick("from idle", cyc);
    check("from idle period", 32'(cyc), 32'(DIV));
    stop = 1'b1;
    step();
    start = 1'b1;
    step();
    check("hold start+stop idle {leds,bin,run}", 32'({leds, bin, running}), 32'd0);
    step();
    check("idle start+stop stays idle", 32'(running), 32'd0);
    idle_inputs();

    // Async reset mid-run at bin=5, then first step DIV cycles after start.
    do_reset();
    start_run();
    repeat (5) wait_tick("to bin 5", cyc);
    check("reached bin 5", 32'(bin), 32'd5);
    step();
    #2;
    rst = 1'b0;
    #1;
    check("async reset outputs", 32'({leds, bin, tick, wrap, running}), 32'd0);
    step();
    rst = 1'b1;
    step();
    check("running after release", 32'(running), 32'd0);
    start_run();
    wait_tick("first after reset", cyc);
    check("first after reset period", 32'(cyc), 32'(DIV));
    check("first after reset leds", 32'(leds), 32'd1);

    // Saturation at all-ones, then clk_en freeze.
    do_reset();
    load = 1'b1; load_gray = 4'b1000;
    step();
    load = 1'b0;
    check("sat load bin", 32'(s_bin), 32'hF);
    start_run();
    wait_tick("sat up", cyc);
    check("sat up {leds,tick,wrap}", 32'({s_leds, s_tick, s_wrap}), 32'({4'b1000, 2'b10}));
    check("wrap up {leds,wrap}", 32'({leds, wrap}), 32'b00001);
    step();
    clk_en = 1'b0;
    ticks = 0;
    repeat (10) begin step(); ticks += int'(tick) + int'(s_tick); end
    check("clk_en=0 no tick", 32'(ticks), 32'd0);
    clk_en = 1'b1;
    wait_tick("after clk_en", cyc);
    check("pc frozen by clk_en", 32'(cyc), 32'd3);
    check("sat still at end", 32'(s_leds), 32'b1000);

    // Randomized run against the behavioural model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      load      = ($urandom_range(0, 39) == 0);
      load_gray = 4'($urandom_range(0, MOD - 1));
      clk_en    = ($urandom_range(0, 7) != 0);
      m_wrap = model_next(m_wrap, 1'b0, start, stop, dir, load, int'(load_gray), clk_en);
      m_sat  = model_next(m_sat,  1'b1, start, stop, dir, load, int'(load_gray), clk_en);
      step();
      check($sformatf("rand %0d wrap-mode", c),
            32'({leds, bin, tick, wrap, running}), 32'(model_pack(m_wrap)));
      check($sformatf("rand %0d sat-mode", c),
            32'({s_leds, s_bin, s_tick, s_wrap, s_running}), 32'(model_pack(m_sat)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
